// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared state type and default constants for the F1 start-light sequencer
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        HOLD  = 2'd2,
        OFF   = 2'd3
    } f1_state_t;

    localparam int F1_N_LIGHTS  = 8;
    localparam int F1_RAND_W    = 7;
    localparam int F1_MIN_DELAY = 2;

endpackage

// File: rtl/tick_countdown.sv
// rtl/tick_countdown.sv - loadable tick down-counter, expires on the tick that sees count 1
module tick_countdown #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority; otherwise each tick decrements, saturating at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = tick && !load && (count_q == W'(1));

endmodule

// File: rtl/f1_sequencer.sv
// rtl/f1_sequencer.sv - start-light sequencer top; optional abort input under F1_SEQ_ABORT_EN
module f1_sequencer
    import f1_pkg::*;
#(
    parameter int N_LIGHTS  = F1_N_LIGHTS,
    parameter int RAND_W    = F1_RAND_W,
    parameter int MIN_DELAY = F1_MIN_DELAY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic                tick,
    input  logic [RAND_W-1:0]   random,
    output logic                lfsr_en,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                done
`ifdef F1_SEQ_ABORT_EN
    ,
    input  logic                abort
`endif
);

    localparam logic [N_LIGHTS-1:0] ALL_ON     = {N_LIGHTS{1'b1}};
    localparam logic [N_LIGHTS-1:0] LAMP_FIRST = N_LIGHTS'(1);
    localparam logic [RAND_W-1:0]   MIN_D      = RAND_W'(MIN_DELAY);

    f1_state_t           state_q, state_d;
    logic [N_LIGHTS-1:0] data_out_q, data_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                trigger_q, trigger_d;

    logic                trig_rise;
    logic                abort_req;
    logic                cd_load;
    logic                cd_expire;
    logic [RAND_W-1:0]   hold_delay;
    logic [N_LIGHTS-1:0] next_pattern;

`ifdef F1_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign trig_rise    = trigger && !trigger_q;
    assign hold_delay   = (random < MIN_D) ? MIN_D : random;
    assign next_pattern = (data_out_q << 1) | LAMP_FIRST;

    tick_countdown #(
        .W(RAND_W)
    ) u_countdown (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cd_load),
        .load_val(hold_delay),
        .tick    (tick && (state_q == HOLD)),
        .expire  (cd_expire)
    );

    // Next-state and registered-output decode; trigger edges outside IDLE are dropped.
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        trigger_d  = trigger;
        cd_load    = 1'b0;
        case (state_q)
            IDLE: begin
                data_out_d = '0;
                busy_d     = 1'b0;
                if (trig_rise) begin
                    data_out_d = LAMP_FIRST;
                    busy_d     = 1'b1;
                    if (LAMP_FIRST == ALL_ON) begin
                        state_d = HOLD;
                        cd_load = 1'b1;
                    end else begin
                        state_d = LIGHT;
                    end
                end
            end
            LIGHT: begin
                if (abort_req) begin
                    state_d    = IDLE;
                    data_out_d = '0;
                    busy_d     = 1'b0;
                end else if (tick) begin
                    data_out_d = next_pattern;
                    if (next_pattern == ALL_ON) begin
                        state_d = HOLD;
                        cd_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (abort_req) begin
                    state_d    = IDLE;
                    data_out_d = '0;
                    busy_d     = 1'b0;
                end else if (cd_expire) begin
                    state_d    = OFF;
                    data_out_d = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            OFF: begin
                state_d    = IDLE;
                data_out_d = '0;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                data_out_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; trigger_q resets high so a held trigger is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            trigger_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            trigger_q  <= trigger_d;
        end
    end

    assign lfsr_en  = (state_q != HOLD);
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
